// File: rtl/csa_resolve_accum.sv
// csa_resolve_accum: streaming multi-operand accumulator with a carry-save core.
// Each accepted operand is folded into a redundant sum/carry pair with one 3:2
// compression. On the last operand of a packet the pair is resolved to binary
// CHUNK bits per cycle, then the result is offered on a valid/ready output.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  operand handshake; in_data is an unsigned WIDTH-bit operand
//   in_last         marks the final operand of a packet (qualified by handshake)
//   out_valid/ready result handshake
//   out_sum         resolved packet sum, modulo 2^ACC_W
//   out_count       operands in the packet, saturating at 255
module csa_resolve_accum #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned ACC_W = 8,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [7:0]       out_count
);

    localparam int unsigned N      = ACC_W / CHUNK;
    localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned BASE_W = (ACC_W > 1) ? $clog2(ACC_W) : 1;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_RESOLVE = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    state_e             state_q,     state_d;
    logic [ACC_W-1:0]   s_q,         s_d;
    logic [ACC_W-1:0]   c_q,         c_d;
    logic [CNT_W-1:0]   count_q,     count_d;
    logic [IDX_W-1:0]   idx_q,       idx_d;
    logic               rcy_q,       rcy_d;
    logic [ACC_W-1:0]   out_sum_q,   out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;
    logic               in_ready_q,  in_ready_d;
    logic               out_valid_q, out_valid_d;

    // Combinational helpers
    logic [ACC_W-1:0]   opnd;
    logic               in_hs;
    logic               out_hs;
    logic [BASE_W-1:0]  base;
    logic [CHUNK-1:0]   s_chunk;
    logic [CHUNK-1:0]   c_chunk;
    logic [CHUNK:0]     chunk_sum;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            rcy_q       <= 1'b0;
            out_sum_q   <= '0;
            out_count_q <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            c_q         <= c_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            rcy_q       <= rcy_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, 3:2 fold, chunked resolve and registered handshake flags
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        c_d         = c_q;
        count_d     = count_q;
        idx_d       = idx_q;
        rcy_d       = rcy_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;

        opnd      = ACC_W'(in_data);
        in_hs     = in_valid & in_ready_q & (state_q == ST_ACCUM);
        out_hs    = out_valid_q & out_ready & (state_q == ST_OUTPUT);
        base      = BASE_W'(idx_q) * BASE_W'(CHUNK);
        s_chunk   = s_q[base +: CHUNK];
        c_chunk   = c_q[base +: CHUNK];
        chunk_sum = {1'b0, s_chunk} + {1'b0, c_chunk} + (CHUNK + 1)'(rcy_q);

        case (state_q)
            ST_ACCUM: begin
                if (in_hs) begin
                    s_d     = s_q ^ c_q ^ opnd;
                    // Majority shifted up one place; the carry out of the MSB is dropped.
                    c_d     = ((s_q & c_q) | (s_q & opnd) | (c_q & opnd)) << 1;
                    count_d = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                    if (in_last) begin
                        state_d = ST_RESOLVE;
                        idx_d   = '0;
                        rcy_d   = 1'b0;
                    end
                end
            end
            ST_RESOLVE: begin
                out_sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                rcy_d                    = chunk_sum[CHUNK];
                if (idx_q == IDX_W'(N - 1)) begin
                    out_count_d = count_q;
                    idx_d       = '0;
                    state_d     = ST_OUTPUT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_OUTPUT: begin
                if (out_hs) begin
                    s_d     = '0;
                    c_d     = '0;
                    count_d = '0;
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase

        // Handshake flags track the state being entered so they stay registered.
        in_ready_d  = (state_d == ST_ACCUM);
        out_valid_d = (state_d == ST_OUTPUT);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

endmodule

// File: tb/tb_csa_resolve_accum.sv
// Self-checking bench for csa_resolve_accum: scenario tasks compare the DUT
// against a plain-arithmetic packet model (sum mod 2^ACC_W, saturating count).
module tb_csa_resolve_accum;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned ACC_W = 8;
    localparam int unsigned CHUNK = 4;
    localparam int unsigned MOD   = 1 << ACC_W;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic [7:0]       out_count;

    int n_checks;
    int n_fail;
    int unsigned pkt_q[$];

    csa_resolve_accum #(.WIDTH(WIDTH), .ACC_W(ACC_W), .CHUNK(CHUNK)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every operand in pkt_q; bubble_mode 0: none, 1: one bubble before each, 2: random.
    // Bubbles raise in_last without in_valid, which must be ignored.
    task automatic drive_packet(input int bubble_mode, output int unsigned exp_sum,
                                output int unsigned exp_cnt, output bit to);
        int guard;
        exp_sum = 0;
        exp_cnt = 0;
        to      = 1'b0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (bubble_mode == 1 || (bubble_mode == 2 && ($urandom % 2) == 1)) begin
                in_valid = 1'b0;
                in_last  = 1'b1;
                in_data  = WIDTH'($urandom);
                tick();
            end
            in_valid = 1'b1;
            in_data  = WIDTH'(pkt_q[i]);
            in_last  = (i == pkt_q.size() - 1);
            guard    = 0;
            while (!in_ready && guard < 50) begin
                tick();
                guard++;
            end
            if (guard >= 50) to = 1'b1;
            tick();
            in_valid = 1'b0;
            in_last  = 1'b0;
            exp_sum  = (exp_sum + pkt_q[i]) % MOD;
            exp_cnt  = (exp_cnt < 255) ? exp_cnt + 1 : 255;
        end
    endtask

    task automatic wait_valid(output int edges, output bit to);
        edges = 0;
        while (!out_valid && edges < 50) begin
            tick();
            edges++;
        end
        to = !out_valid;
    endtask

    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 8'd0 || out_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%0b rdy=%0b sum=%0d cnt=%0d, want 0 0 0 0",
                     out_valid, in_ready, out_sum, out_count);
        end
        tick();
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready_early: got %0b want 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got rdy=%0b v=%0b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_chunk_carry();
        int unsigned es, ec;
        bit to;
        out_ready = 1'b1;
        pkt_q = '{15, 15, 15};
        drive_packet(0, es, ec, to);
        n_checks++;
        if (to || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_k0: got to=%0b rdy=%0b v=%0b want 0 0 0", to, in_ready, out_valid);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL carry_k1: got rdy=%0b v=%0b want 0 0", in_ready, out_valid);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== 8'd45 || out_count !== 8'd3
            || es != 45 || ec != 3) begin
            n_fail++;
            $display("FAIL carry_result: got rdy=%0b v=%0b sum=%0d cnt=%0d want 0 1 45 3",
                     in_ready, out_valid, out_sum, out_count);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL carry_return: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_bubbles();
        int unsigned es, ec;
        int edges;
        bit to, to2;
        pkt_q = {};
        for (int i = 0; i < 18; i++) pkt_q.push_back(15);
        drive_packet(1, es, ec, to);
        wait_valid(edges, to2);
        n_checks++;
        if (to || to2 || out_sum !== ACC_W'(es) || out_count !== 8'(ec) || es != 14 || ec != 18) begin
            n_fail++;
            $display("FAIL bubbles: got sum=%0d cnt=%0d to=%0b/%0b want sum=14 cnt=18",
                     out_sum, out_count, to, to2);
        end
        accept();
    endtask

    task automatic test_back_pressure();
        int unsigned es, ec;
        int edges;
        bit to, to2;
        pkt_q = {};
        for (int i = 0; i < int'($urandom_range(2, 10)); i++) pkt_q.push_back($urandom_range(0, 15));
        drive_packet(0, es, ec, to);
        wait_valid(edges, to2);
        n_checks++;
        if (to || to2 || edges != 2) begin
            n_fail++;
            $display("FAIL bp_latency: got edges=%0d to=%0b/%0b want 2", edges, to, to2);
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== ACC_W'(es) || out_count !== 8'(ec)) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got v=%0b rdy=%0b sum=%0d cnt=%0d want 1 0 %0d %0d",
                         i, out_valid, in_ready, out_sum, out_count, es, ec);
            end
            in_valid = 1'b1;
            in_data  = WIDTH'($urandom);
            tick();
        end
        in_valid = 1'b0;
        accept();
        pkt_q = '{7};
        drive_packet(0, es, ec, to);
        wait_valid(edges, to2);
        n_checks++;
        if (to || to2 || out_sum !== 8'd7 || out_count !== 8'd1) begin
            n_fail++;
            $display("FAIL single_after_bp: got sum=%0d cnt=%0d want 7 1", out_sum, out_count);
        end
        accept();
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_return: got v=%0b rdy=%0b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_saturate();
        int unsigned es, ec;
        int edges;
        bit to, to2;
        pkt_q = {};
        for (int i = 0; i < 300; i++) pkt_q.push_back(1);
        drive_packet(0, es, ec, to);
        wait_valid(edges, to2);
        n_checks++;
        if (to || to2 || out_sum !== 8'd44 || out_count !== 8'd255 || es != 44 || ec != 255) begin
            n_fail++;
            $display("FAIL saturate: got sum=%0d cnt=%0d want 44 255", out_sum, out_count);
        end
        accept();
    endtask

    task automatic test_reset_resolve();
        int unsigned es, ec;
        int edges;
        bit to, to2;
        pkt_q = '{5, 9};
        drive_packet(0, es, ec, to);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b0 || out_sum !== 8'd0 || out_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_in_resolve: got v=%0b rdy=%0b sum=%0d cnt=%0d want 0 0 0 0",
                     out_valid, in_ready, out_sum, out_count);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold_valid: got %0b want 0", out_valid);
        end
        rst_n = 1'b1;
        tick();
        pkt_q = '{3, 4};
        drive_packet(0, es, ec, to);
        wait_valid(edges, to2);
        n_checks++;
        if (to || to2 || out_sum !== 8'd7 || out_count !== 8'd2) begin
            n_fail++;
            $display("FAIL after_reset_packet: got sum=%0d cnt=%0d want 7 2", out_sum, out_count);
        end
        accept();
    endtask

    task automatic test_random_packets();
        int unsigned es, ec;
        int edges;
        bit to, to2;
        for (int p = 0; p < 8; p++) begin
            pkt_q = {};
            for (int i = 0; i < int'($urandom_range(1, 40)); i++) pkt_q.push_back($urandom_range(0, 15));
            out_ready = ($urandom % 2) == 1;
            drive_packet(2, es, ec, to);
            wait_valid(edges, to2);
            n_checks++;
            if (to || to2 || out_sum !== ACC_W'(es) || out_count !== 8'(ec)) begin
                n_fail++;
                $display("FAIL random_pkt[%0d]: got sum=%0d cnt=%0d want %0d %0d",
                         p, out_sum, out_count, es, ec);
            end
            out_ready = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            accept();
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        test_reset();
        test_chunk_carry();
        test_bubbles();
        test_back_pressure();
        test_saturate();
        test_reset_resolve();
        test_random_packets();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
